bus_access_arbiter: RTL and testbench
=====================================

BUS_ACCESS_ARBITER -- requirements
Module: bus_access_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- DATA_WIDTH, 8, data bus width.
- ADDR_WIDTH, 16, address bus width.
- MEM_START_ADDR, 8'h40, first data-memory address.
- MEM_STOP_ADDR, 8'hBF, last data-memory address.
- IO_START_ADDR, 8'h00, first I/O address.
- IO_STOP_ADDR, 8'h3F, last I/O address.
- MEM_WAIT, 2, memory wait states (0-15).
- IO_WAIT, 0, I/O wait states (0-15).

REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req / dma_req  input  1  access request; held high until the matching done.
- cpu_we / dma_we  input  1  1 = write, 0 = read.
- cpu_addr / dma_addr  input  ADDR_WIDTH  absolute address.
- cpu_wdata / dma_wdata  input  DATA_WIDTH  write data.
- cpu_gnt / dma_gnt  output  1  one-cycle grant pulse.
- cpu_done / dma_done  output  1  one-cycle completion pulse.
- rdata  output  DATA_WIDTH  registered read data; valid while done is high.
- err  output  1  high with done when the address hit no region.
- bus_addr  output  ADDR_WIDTH  region-relative address.
- bus_wdata  output  DATA_WIDTH  write data to the bus.
- bus_rdata  input  DATA_WIDTH  read data from the bus.
- mem_cs, mem_we, mem_oe  output  1  each  memory strobes.
- io_cs, io_we, io_oe  output  1  each  I/O strobes.
- busy  output  1  high in every state except IDLE.

Function
REQ-003 SHALL implement the states IDLE, ACCESS and DONE.
REQ-004 In IDLE, when any request is high, SHALL on that edge latch the winner's addr, we and wdata plus the owner ID, then go to ACCESS; with no request, SHALL stay in IDLE.
REQ-005 SHALL pulse the owner's gnt for exactly one cycle, in the first ACCESS cycle.
REQ-006 SHALL decode the region from the latched address:
- MEM_START_ADDR..MEM_STOP_ADDR selects memory.
- IO_START_ADDR..IO_STOP_ADDR selects I/O.
- Any other address selects none.
- Range checks are inclusive.
REQ-007 In ACCESS, SHALL assert the selected cs for exactly 1+W cycles (W = MEM_WAIT or IO_WAIT), using a 4-bit down-counter loaded on entry.
- we = latched we; oe = !we.
- Strobes of the unselected region stay 0.
REQ-008 SHALL drive bus_addr = latched address minus the selected region start, and bus_wdata = latched wdata, throughout ACCESS.
REQ-009 On the final ACCESS cycle of a read, SHALL capture bus_rdata into rdata.
- rdata holds its value until the next read capture.
REQ-010 For an unmapped address, SHALL assert no cs, spend exactly one cycle in ACCESS, and raise err together with done.
REQ-011 In DONE, SHALL pulse the owner's done for one cycle, then return to IDLE.
- Request-to-done latency: done is high in cycle N+2+W when the request is sampled at edge N.
REQ-012 Changes to req, addr, we or wdata after latching SHALL NOT affect the transaction in progress; a request dropped mid-transaction still completes.
REQ-013 Outside ACCESS, SHALL hold every cs/we/oe at 0 and bus_addr/bus_wdata at 0; outputs are never driven to x or z.
REQ-014 SHALL start a new grant no earlier than the IDLE cycle that follows DONE.

Reset
REQ-015 Asserting reset (low) at any time, including mid-transaction, SHALL immediately force:
- state = IDLE, counter = 0.
- all gnt/done/err/strobes = 0, busy = 0.
- bus_addr, bus_wdata and rdata = 0.
- last-grant pointer = DMA, so the CPU wins the first tie.
REQ-016 An aborted transaction SHALL produce no done; a requester still holding req after reset SHALL be re-arbitrated normally.

Configuration
REQ-017 Macro BUS_ARB_ROUND_ROBIN_EN:
- Defined: simultaneous requests SHALL go to the requester not granted last; the last-grant pointer updates on every grant.
- Undefined: the CPU SHALL always win simultaneous requests, and the last-grant pointer is removed.
- A single requester is granted immediately in both builds.

Verification
REQ-018 CPU read 8'h50 (MEM_WAIT=2), bus_rdata=8'hA5 -> mem_cs/mem_oe high for cycles 1-3, bus_addr=16'h0010, cpu_done and rdata=8'hA5 in cycle 4.
REQ-019 DMA write 8'h3D, data 8'h7E (IO_WAIT=0) -> io_cs/io_we high for cycle 1 only, bus_addr=16'h003D, bus_wdata=8'h7E, dma_done in cycle 2, mem_cs never high.
REQ-020 CPU read 16'h00C0 -> no cs asserted, cpu_done and err high in cycle 2.
REQ-021 Both requesters hold req for back-to-back accesses -> round-robin build grants CPU, DMA, CPU, DMA; fixed build grants CPU every time.
REQ-022 Reset asserted in the second cycle of a memory ACCESS -> all strobes 0 within the same cycle, no done; after release with req still high, the access restarts from IDLE.
REQ-023 Requester drops req and changes addr mid-ACCESS -> original address kept for the full 1+W cycles, and done still pulses.

Source files
------------

// File: rtl/bus_access_arbiter.sv
// -----------------------------------------------------------------------------
// bus_access_arbiter
//   Arbitrates a CPU and a DMA requester onto one shared bus that reaches a
//   data-memory region and an I/O region. A single winner is latched in IDLE,
//   the selected region is strobed for 1+W cycles in ACCESS, and completion is
//   signalled in DONE. All outputs are registered.
//
//   Build option: BUS_ARB_ROUND_ROBIN_EN
//     defined   -> simultaneous requests alternate (last-grant pointer kept)
//     undefined -> CPU always wins simultaneous requests
//
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata           CPU request channel
//   dma_req/we/addr/wdata           DMA request channel
//   cpu_gnt, dma_gnt                one-cycle grant pulses
//   cpu_done, dma_done              one-cycle completion pulses
//   rdata                           last captured read data
//   err                             unmapped-address flag, valid with done
//   bus_addr, bus_wdata, bus_rdata  region-relative shared bus
//   mem_cs/we/oe, io_cs/we/oe       region strobes
//   busy                            high whenever not IDLE
// -----------------------------------------------------------------------------
module bus_access_arbiter #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR = 16'h0040,
  parameter logic [ADDR_WIDTH-1:0] MEM_STOP_ADDR  = 16'h00BF,
  parameter logic [ADDR_WIDTH-1:0] IO_START_ADDR  = 16'h0000,
  parameter logic [ADDR_WIDTH-1:0] IO_STOP_ADDR   = 16'h003F,
  parameter int unsigned           MEM_WAIT       = 2,
  parameter int unsigned           IO_WAIT        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  cpu_gnt,
  output logic                  dma_gnt,
  output logic                  cpu_done,
  output logic                  dma_done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  io_cs,
  output logic                  io_we,
  output logic                  io_oe,
  output logic                  busy
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2} state_t;
  typedef enum logic [1:0] {RG_NONE = 2'd0, RG_MEM = 2'd1, RG_IO = 2'd2} region_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Inclusive range test written as an offset compare so a zero start
  // address does not produce a constant comparison.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [ADDR_WIDTH-1:0] lo,
                                    input logic [ADDR_WIDTH-1:0] hi);
    return ((a - lo) <= (hi - lo));
  endfunction

  function automatic region_t decode_region(input logic [ADDR_WIDTH-1:0] a);
    if (in_range(a, MEM_START_ADDR, MEM_STOP_ADDR)) return RG_MEM;
    else if (in_range(a, IO_START_ADDR, IO_STOP_ADDR)) return RG_IO;
    else return RG_NONE;
  endfunction

  state_t                  state_q, state_d;
  region_t                 region_q, region_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    pick_dma;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic                    last_q, last_d;
`endif

  logic                    cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d;
  logic                    cpu_done_q, cpu_done_d, dma_done_q, dma_done_d;
  logic                    err_q, err_d, busy_q, busy_d;
  logic                    mem_cs_q, mem_cs_d, mem_we_q, mem_we_d, mem_oe_q, mem_oe_d;
  logic                    io_cs_q, io_cs_d, io_we_q, io_we_d, io_oe_q, io_oe_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;

  // Next-state, latched-transaction and registered-output computation.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    pick_dma = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    last_d   = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          if (cpu_req && dma_req) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
            pick_dma = (last_q == OWN_CPU);
`else
            pick_dma = 1'b0;
`endif
          end else begin
            pick_dma = dma_req;
          end
          owner_d  = pick_dma ? OWN_DMA : OWN_CPU;
          addr_d   = pick_dma ? dma_addr : cpu_addr;
          we_d     = pick_dma ? dma_we : cpu_we;
          wdata_d  = pick_dma ? dma_wdata : cpu_wdata;
          region_d = decode_region(addr_d);
          case (region_d)
            RG_MEM:  cnt_d = 4'(MEM_WAIT);
            RG_IO:   cnt_d = 4'(IO_WAIT);
            default: cnt_d = 4'd0;
          endcase
`ifdef BUS_ARB_ROUND_ROBIN_EN
          last_d   = owner_d;
`endif
          state_d  = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Unmapped reads leave rdata untouched: nothing drove the bus.
          if (!we_q && (region_q != RG_NONE)) begin
            rdata_d = bus_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they line up
    // with the state they describe.
    cpu_gnt_d  = (state_q == ST_IDLE) && (state_d == ST_ACCESS) && (owner_d == OWN_CPU);
    dma_gnt_d  = (state_q == ST_IDLE) && (state_d == ST_ACCESS) && (owner_d == OWN_DMA);
    cpu_done_d = (state_d == ST_DONE) && (owner_d == OWN_CPU);
    dma_done_d = (state_d == ST_DONE) && (owner_d == OWN_DMA);
    err_d      = (state_d == ST_DONE) && (region_d == RG_NONE);
    busy_d     = (state_d != ST_IDLE);
    mem_cs_d   = (state_d == ST_ACCESS) && (region_d == RG_MEM);
    mem_we_d   = mem_cs_d && we_d;
    mem_oe_d   = mem_cs_d && !we_d;
    io_cs_d    = (state_d == ST_ACCESS) && (region_d == RG_IO);
    io_we_d    = io_cs_d && we_d;
    io_oe_d    = io_cs_d && !we_d;
    if (mem_cs_d) begin
      bus_addr_d  = addr_d - MEM_START_ADDR;
      bus_wdata_d = wdata_d;
    end else if (io_cs_d) begin
      bus_addr_d  = addr_d - IO_START_ADDR;
      bus_wdata_d = wdata_d;
    end else begin
      bus_addr_d  = {ADDR_WIDTH{1'b0}};
      bus_wdata_d = {DATA_WIDTH{1'b0}};
    end
  end

  // State, transaction latch and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      region_q    <= RG_NONE;
      cnt_q       <= 4'd0;
      owner_q     <= OWN_CPU;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      we_q        <= 1'b0;
      wdata_q     <= {DATA_WIDTH{1'b0}};
      rdata_q     <= {DATA_WIDTH{1'b0}};
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_q      <= OWN_DMA;
`endif
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      io_cs_q     <= 1'b0;
      io_we_q     <= 1'b0;
      io_oe_q     <= 1'b0;
      bus_addr_q  <= {ADDR_WIDTH{1'b0}};
      bus_wdata_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      region_q    <= region_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      io_cs_q     <= io_cs_d;
      io_we_q     <= io_we_d;
      io_oe_q     <= io_oe_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign dma_gnt   = dma_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign dma_done  = dma_done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign io_cs     = io_cs_q;
  assign io_we     = io_we_q;
  assign io_oe     = io_oe_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_bus_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_access_arbiter
//   Directed bench for bus_access_arbiter with default parameters. Expected
//   transaction results are pushed to a scoreboard queue when a request is
//   driven and popped when the DUT reports done.
// -----------------------------------------------------------------------------
module tb_bus_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_gnt, dma_gnt, cpu_done, dma_done, err, busy;
  logic [7:0]  rdata, bus_wdata, bus_rdata;
  logic [15:0] bus_addr;
  logic        mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe;

  int tests = 0;
  int fails = 0;
  logic [7:0] model_rdata = 8'h00;

  typedef struct {
    int          region;     // 0 none, 1 mem, 2 io
    logic [15:0] bus_addr;
    int          cs_cycles;
    int          done_cycle;
    logic        err;
    logic [7:0]  rdata;
  } exp_t;
  exp_t sb[$];
  logic exp_owner[$];

  bus_access_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_done(cpu_done), .dma_done(dma_done),
    .rdata(rdata), .err(err), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .io_cs(io_cs), .io_we(io_we), .io_oe(io_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction from one requester; called at a negedge with the DUT idle.
  task automatic txn(input logic dma, input logic we, input logic [15:0] addr,
                     input logic [7:0] wd, input logic [7:0] brd, input int mid_cycle);
    exp_t e;
    int   w, gnt_cyc, gnt_cnt, cs_cnt, wrong, bad, done_cyc;
    logic err_v, busy_v, sel_cs, sel_we, sel_oe;
    logic [7:0] rd_v;
    if (addr >= 16'h0040 && addr <= 16'h00BF) begin
      e.region = 1; e.bus_addr = addr - 16'h0040; w = 2;
    end else if (addr <= 16'h003F) begin
      e.region = 2; e.bus_addr = addr; w = 0;
    end else begin
      e.region = 0; e.bus_addr = 16'h0000; w = 0;
    end
    e.cs_cycles  = (e.region == 0) ? 0 : 1 + w;
    e.done_cycle = 2 + w;
    e.err        = (e.region == 0);
    if (!we && e.region != 0) model_rdata = brd;
    e.rdata = model_rdata;
    sb.push_back(e);

    bus_rdata = brd;
    if (dma) begin dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd; end
    else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end

    gnt_cyc = 0; gnt_cnt = 0; cs_cnt = 0; wrong = 0; bad = 0; done_cyc = 0;
    err_v = 1'b0; busy_v = 1'b0; rd_v = 8'h00;
    for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
      @(negedge clk);
      if (dma ? dma_gnt : cpu_gnt) begin gnt_cnt++; if (gnt_cyc == 0) gnt_cyc = k; end
      if (dma ? (cpu_gnt || cpu_done) : (dma_gnt || dma_done)) wrong++;
      sel_cs = (e.region == 1) ? mem_cs : (e.region == 2) ? io_cs : 1'b0;
      sel_we = (e.region == 1) ? mem_we : (e.region == 2) ? io_we : 1'b0;
      sel_oe = (e.region == 1) ? mem_oe : (e.region == 2) ? io_oe : 1'b0;
      if (sel_cs) begin
        cs_cnt++;
        if (bus_addr !== e.bus_addr) bad++;
        if (sel_we !== we || sel_oe !== !we) bad++;
        if (we && bus_wdata !== wd) bad++;
      end
      if (e.region != 1 && (mem_cs || mem_we || mem_oe)) wrong++;
      if (e.region != 2 && (io_cs || io_we || io_oe)) wrong++;
      if (dma ? dma_done : cpu_done) begin
        done_cyc = k; err_v = err; rd_v = rdata; busy_v = busy;
      end
      if (k == mid_cycle) begin
        if (dma) begin dma_req = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'hFF; end
        else     begin cpu_req = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'hFF; end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);

    e = sb.pop_front();
    check("gnt_cycle", gnt_cyc, 1);
    check("gnt_count", gnt_cnt, 1);
    check("cs_cycles", cs_cnt, e.cs_cycles);
    check("bus_fields", bad, 0);
    check("stray_activity", wrong, 0);
    check("done_cycle", done_cyc, e.done_cycle);
    check("err", err_v, e.err);
    check("busy_at_done", busy_v, 1'b1);
    if (!(e.err && !we)) check("rdata", rd_v, e.rdata);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    int grants, dones, seen;
    logic got;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
    bus_rdata = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {cpu_gnt, dma_gnt, cpu_done, dma_done, err, busy}, 6'b0);
    check("reset_strb", {mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe}, 6'b0);
    check("reset_bus", {bus_addr, bus_wdata, rdata}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    txn(1'b0, 1'b0, 16'h0050, 8'h00, 8'hA5, 0);  // memory read
    txn(1'b1, 1'b1, 16'h003D, 8'h7E, 8'h00, 0);  // I/O write
    txn(1'b0, 1'b0, 16'h00C0, 8'h00, 8'h99, 0);  // unmapped
    txn(1'b0, 1'b0, 16'h0040, 8'h00, 8'h11, 0);  // memory low edge
    txn(1'b1, 1'b0, 16'h00BF, 8'h00, 8'h22, 0);  // memory high edge
    txn(1'b0, 1'b1, 16'h003F, 8'hC3, 8'h00, 0);  // I/O high edge
    txn(1'b1, 1'b0, 16'h0000, 8'h00, 8'h33, 0);  // I/O low edge
    txn(1'b1, 1'b1, 16'h0080, 8'h5A, 8'h00, 0);  // memory write

    // Both requesters held: arbitration order.
`ifdef BUS_ARB_ROUND_ROBIN_EN
    exp_owner = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_owner = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
    bus_rdata = 8'h44;
    grants = 0; dones = 0;
    for (int c = 0; c < 60 && dones < 4; c++) begin
      @(negedge clk);
      if (cpu_gnt || dma_gnt) begin
        got = dma_gnt;
        check("arb_one_gnt", {cpu_gnt, dma_gnt} == 2'b11, 1'b0);
        if (exp_owner.size() > 0) check("arb_owner", got, exp_owner.pop_front());
        grants++;
      end
      if (cpu_done || dma_done) dones++;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check("arb_grants", grants, 4);
    model_rdata = 8'h44;
    repeat (2) @(negedge clk);

    // Reset in the second cycle of a memory access.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0050; bus_rdata = 8'h3C;
    repeat (2) @(negedge clk);
    check("pre_reset_cs", mem_cs, 1'b1);
    reset = 1'b0;
    #1;
    check("rst_strb", {mem_cs, mem_we, mem_oe, io_cs, io_we, io_oe}, 6'b0);
    check("rst_ctrl", {busy, cpu_gnt, cpu_done, err}, 4'b0);
    check("rst_bus", {bus_addr, rdata}, 24'h0);
    model_rdata = 8'h00;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_done || dma_done) seen++;
    end
    check("rst_no_done", seen, 0);
    reset = 1'b1;
    txn(1'b0, 1'b0, 16'h0050, 8'h00, 8'h3C, 0);  // re-arbitrated after reset

    // Request dropped and address changed mid-access.
    txn(1'b0, 1'b0, 16'h0060, 8'h00, 8'h5B, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
